// File: rtl/button_input_pkg.sv
// Shared state encoding, 100 MHz timing defaults and counter width helper
// for the button input controller.
package button_input_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_e;

  localparam int DEF_N_BUTTONS      = 4;
  localparam int DEF_TICK_DIV       = 100000;
  localparam int DEF_DEBOUNCE_TICKS = 10;
  localparam int DEF_REPEAT_EN      = 1;
  localparam int DEF_REPEAT_DELAY   = 400;
  localparam int DEF_REPEAT_RATE    = 100;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/button_input_ctrl_channel.sv
// One button channel: tick-based debounce FSM with press/release/auto-repeat pulses.
//
// state     | meaning
// IDLE      | debounced level low, input low
// PRESS_CHK | input high, counting stable ticks toward a press
// HELD      | press accepted, counting ticks toward the next repeat
// REL_CHK   | input low while held, counting stable ticks toward a release
module button_channel
  import button_input_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int REPEAT_EN      = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_button,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int DEB_W = cnt_w(DEBOUNCE_TICKS);
  localparam int RPT_W = cnt_w(REPEAT_DELAY);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_TICKS);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RELOAD =
    RPT_W'((REPEAT_DELAY >= REPEAT_RATE) ? (REPEAT_DELAY - REPEAT_RATE) : 0);

  btn_state_e       state_q, state_d;
  logic [DEB_W-1:0] deb_q, deb_d, deb_inc;
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    rpt_d     = rpt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    deb_inc   = deb_q + DEB_W'(1);
    rpt_inc   = rpt_q + RPT_W'(1);

    case (state_q)
      IDLE: begin
        if (i_button) begin
          state_d = PRESS_CHK;
          deb_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!i_button) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (i_tick) begin
          if (deb_inc == DEB_LAST) begin
            state_d = HELD;
            deb_d   = '0;
            rpt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            deb_d = deb_inc;
          end
        end
      end
      HELD: begin
        if (!i_button) begin
          state_d = REL_CHK;
          deb_d   = '0;
        end else if (i_tick && (REPEAT_EN != 0)) begin
          // Reloading below REPEAT_DELAY gives the steady REPEAT_RATE cadence.
          if (rpt_inc == RPT_LAST) begin
            repeat_d = 1'b1;
            rpt_d    = RPT_RELOAD;
          end else begin
            rpt_d = rpt_inc;
          end
        end
      end
      REL_CHK: begin
        if (i_button) begin
          state_d = HELD;
        end else if (i_tick) begin
          if (deb_inc == DEB_LAST) begin
            state_d   = IDLE;
            deb_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            deb_d = deb_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      deb_q     <= '0;
      rpt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      rpt_q     <= rpt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_repeat  = repeat_q;

endmodule

// File: rtl/button_input_ctrl.sv
// Button input controller: shared tick prescaler feeding N independent
// debounce/auto-repeat channels.
module button_input_ctrl
  import button_input_pkg::*;
#(
  parameter int N_BUTTONS      = DEF_N_BUTTONS,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int REPEAT_EN      = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [N_BUTTONS-1:0] i_buttons,
  output logic [N_BUTTONS-1:0] o_level,
  output logic [N_BUTTONS-1:0] o_press,
  output logic [N_BUTTONS-1:0] o_release,
  output logic [N_BUTTONS-1:0] o_repeat,
  output logic                 o_tick
);

  localparam int TICK_W = cnt_w(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam bit PARAMS_OK = (DEBOUNCE_TICKS >= 1) &&
    ((REPEAT_EN == 0) || ((REPEAT_RATE >= 1) && (REPEAT_DELAY >= REPEAT_RATE)));

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_q, tick_d;

  always_comb begin
    tick_d     = 1'b0;
    tick_cnt_d = tick_cnt_q + TICK_W'(1);
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
      tick_d     = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign o_tick = tick_q;

  a_params_ok : assert property (@(posedge i_clock) PARAMS_OK)
    else $error("button_input_ctrl: illegal debounce/repeat parameters");

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_ch
    button_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_tick    (tick_q),
      .i_button  (i_buttons[gi]),
      .o_level   (o_level[gi]),
      .o_press   (o_press[gi]),
      .o_release (o_release[gi]),
      .o_repeat  (o_repeat[gi])
    );
  end

endmodule

// File: doc/button_input_ctrl.md
Name: button_input_ctrl

Overview:
- Sequences the Pong player buttons after the 3-flop input synchronizer.
- Turns synchronized levels into clean game events: time-based debounced level, one-cycle press pulse, release pulse, and auto-repeat pulses while held.
- One shared millisecond tick prescaler drives N identical per-button channels.
- Sits between the synchronizers and the paddle/menu logic.

Parameters:
- N_BUTTONS, 4, number of button channels.
- TICK_DIV, 100000, clock cycles per tick (1 ms at 100 MHz).
- DEBOUNCE_TICKS, 10, consecutive stable ticks required to accept a press or release.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 forces o_repeat low.
- REPEAT_DELAY, 400, ticks held (after the press is accepted) before the first repeat pulse.
- REPEAT_RATE, 100, ticks between subsequent repeat pulses.

Ports:
- i_clock, in, 1, system clock.
- i_reset, in, 1, synchronous, active-high reset.
- i_buttons, in, N_BUTTONS, synchronized button levels; 1 = pressed.
- o_level, out, N_BUTTONS, debounced level per button.
- o_press, out, N_BUTTONS, one-cycle pulse when a press is accepted.
- o_release, out, N_BUTTONS, one-cycle pulse when a release is accepted.
- o_repeat, out, N_BUTTONS, one-cycle auto-repeat pulse.
- o_tick, out, 1, prescaler tick; debug and shared timebase for game logic.

Behaviour:
- Clock and reset: one clock, i_clock. i_reset is synchronous and active-high, sampled on the rising edge of i_clock.
- Reset values: all outputs 0. Prescaler count 0. Every channel in IDLE with all counters 0.
- Reset mid-operation: a channel in any state returns to IDLE on the next edge. No o_release is generated.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - o_tick is registered and is high for exactly the one cycle after the count equals TICK_DIV-1.
  - Period is exactly TICK_DIV cycles.
- Counter widths: each sized with $clog2 of its max value plus 1. No counter ever wraps; each saturates or is cleared by a state change.
- Per-channel FSM, states IDLE, PRESS_CHK, HELD, REL_CHK:
  - IDLE: i_buttons[k]=1 -> PRESS_CHK, stable count cleared to 0.
  - PRESS_CHK, input 0 -> IDLE. No output and no partial credit kept.
  - PRESS_CHK, input 1 on an o_tick cycle -> count+1.
    - When the count reaches DEBOUNCE_TICKS, go to HELD.
    - On that same edge o_level[k] is set to 1 and o_press[k] is pulsed for exactly one cycle.
    - Repeat count is cleared.
  - HELD, input 0 -> REL_CHK, stable count cleared. o_level stays 1.
  - HELD, input 1 on a tick cycle, REPEAT_EN=1 -> repeat count+1.
    - When the repeat count hits REPEAT_DELAY, pulse o_repeat and reload the count to REPEAT_DELAY-REPEAT_RATE.
    - This gives a pulse every REPEAT_RATE ticks thereafter.
  - REL_CHK, input 1 -> HELD.
    - No new o_press.
    - Repeat count is held, not cleared.
    - No repeat pulses are generated while in REL_CHK.
  - REL_CHK, input 0 on a tick cycle -> count+1.
    - At DEBOUNCE_TICKS: go to IDLE, o_level=0, o_release pulsed for one cycle.
- Latency: a clean press is accepted between DEBOUNCE_TICKS-1 and DEBOUNCE_TICKS ticks after the input rises, plus at most 2 cycles. The same bound applies to release.
- Pulse rules:
  - o_press and o_release never occur in the same cycle on a channel.
  - o_press and o_repeat never coincide; the first repeat comes at least REPEAT_DELAY ticks after o_press.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle, with no arbitration loss.
- Debounce constraint: DEBOUNCE_TICKS must be at least 1. If REPEAT_EN=1, also REPEAT_RATE ≥ 1 and REPEAT_DELAY ≥ REPEAT_RATE. The block checks this with a simulation-time assertion.

Decomposition:
- Shared package button_input_pkg holds:
  - The 2-bit FSM state encoding constants IDLE=0, PRESS_CHK=1, HELD=2, REL_CHK=3.
  - Default timing constants for 100 MHz.
  - The $clog2-based width helpers.
- Natural sub-module: button_channel.
  - One FSM plus its debounce and repeat counters.
  - Takes i_clock, i_reset, i_tick and one button bit.
  - Instantiated N_BUTTONS times by a generate loop.
- The prescaler lives in the top level.

Test Plan:
All scenarios use TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2, N_BUTTONS=2.
1. Reset check: assert i_reset for 3 cycles with i_buttons=2'b11 -> all outputs 0 and o_tick low during reset. First o_tick comes exactly 4 cycles after reset release, then every 4 cycles.
2. Clean press/release: button0 high for 60 cycles, then low.
   - o_press[0] pulses once, 8-14 cycles after the rise, and o_level[0] goes high in that same cycle.
   - o_release[0] pulses once, 8-14 cycles after the fall.
   - Channel 1 outputs stay 0 throughout.
3. Bounce rejection: button0 toggles every 3 cycles for 40 cycles, then stays low -> o_level, o_press, o_release and o_repeat all stay 0.
4. Auto-repeat: button1 held for 80 cycles.
   - o_press once.
   - First o_repeat 5 ticks (20 cycles) after o_press, then every 8 cycles.
   - No repeats after the release is accepted.
5. Release glitch: while HELD, drop button0 for 5 cycles then restore -> o_level stays 1 and there is no o_release or o_press. The repeat cadence resumes without resetting its count.
6. Reset mid-operation and simultaneity:
   - Both buttons rise together -> o_press[0] and o_press[1] pulse in the same cycle.
   - Then pulse i_reset while they are HELD -> o_level=0 next cycle with no o_release.
   - Buttons still high -> a full re-debounce produces a fresh o_press.
